// File: rtl/vTPU_pkg.sv
// vTPU_pkg
// Shared types and default constants for the load sequencer slice.
//   load_seq_state_t : sequencer FSM state (IDLE, RUN, DONE)
//   DEFAULT_*        : default widths used by the interface and the modules
//   tile_index_width : width of an index that counts 0 .. rows-1
package vTPU_pkg;

   localparam int DEFAULT_COUNTER_WIDTH = 32;
   localparam int DEFAULT_LENGTH_WIDTH  = 16;
   localparam int DEFAULT_MATRIX_WIDTH  = 14;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } load_seq_state_t;

   // A one-row tile still needs a one-bit index.
   function automatic int tile_index_width(input int rows);
      return (rows > 1) ? $clog2(rows) : 1;
   endfunction

endpackage

// File: rtl/load_sequencer_if.sv
// load_sequencer_if
// Instruction handshake plus row-address stream of the load sequencer.
//   instr_valid/instr_ready : load instruction handshake
//   instr_addr, instr_len   : start address and number of rows
//   addr_valid, addr        : row address issued downstream
//   tile_last, addr_last    : last row of a tile / of the instruction
// modport slave  : the sequencer side
// modport master : the side issuing instructions and consuming addresses
interface load_sequencer_if
   import vTPU_pkg::*;
#(
   parameter int COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH,
   parameter int LENGTH_WIDTH  = DEFAULT_LENGTH_WIDTH
);

   logic                     instr_valid;
   logic                     instr_ready;
   logic [COUNTER_WIDTH-1:0] instr_addr;
   logic [LENGTH_WIDTH-1:0]  instr_len;
   logic                     addr_valid;
   logic [COUNTER_WIDTH-1:0] addr;
   logic                     tile_last;
   logic                     addr_last;

   modport slave (
      input  instr_valid, instr_addr, instr_len,
      output instr_ready, addr_valid, addr, tile_last, addr_last
   );

   modport master (
      output instr_valid, instr_addr, instr_len,
      input  instr_ready, addr_valid, addr, tile_last, addr_last
   );

endinterface

// File: rtl/row_tile_counter.sv
// row_tile_counter
// Row index of the current instruction plus the row position inside a tile.
//   clk, rst  : clock, asynchronous active-low reset
//   clear     : restart both indices at 0
//   advance   : step to the next row
//   len       : row count of the current instruction
//   row       : current row index
//   tile_wrap : current row is the last row of a tile
//   last      : current row is row len-1
module row_tile_counter
   import vTPU_pkg::*;
#(
   parameter int LENGTH_WIDTH = DEFAULT_LENGTH_WIDTH,
   parameter int MATRIX_WIDTH = DEFAULT_MATRIX_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clear,
   input  logic                    advance,
   input  logic [LENGTH_WIDTH-1:0] len,
   output logic [LENGTH_WIDTH-1:0] row,
   output logic                    tile_wrap,
   output logic                    last
);

   localparam int TILE_WIDTH = tile_index_width(MATRIX_WIDTH);
   localparam logic [TILE_WIDTH-1:0]   TILE_MAX = TILE_WIDTH'(MATRIX_WIDTH - 1);
   localparam logic [TILE_WIDTH-1:0]   TILE_ONE = TILE_WIDTH'(1);
   localparam logic [LENGTH_WIDTH-1:0] ROW_ONE  = LENGTH_WIDTH'(1);

   logic [TILE_WIDTH-1:0] tile;

   // Clear wins over advance so a freshly accepted instruction always starts
   // at row 0 / tile position 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         row  <= '0;
         tile <= '0;
      end else if (clear) begin
         row  <= '0;
         tile <= '0;
      end else if (advance) begin
         row  <= row + ROW_ONE;
         tile <= tile_wrap ? '0 : tile + TILE_ONE;
      end
   end

   assign tile_wrap = (tile == TILE_MAX);

   // The row never passes len-1, so a full-scale len cannot overflow row.
   assign last = (row == len - ROW_ONE);

endmodule

// File: rtl/load_sequencer.sv
// load_sequencer
// Turns a (start address, row count) load instruction into a stream of row
// addresses for the downstream load counter.
//   clk, rst : clock, asynchronous active-low reset
//   enable   : global pipeline advance, all state holds while low
//   abort    : cancels the running sequence
//   bus      : instruction handshake and row-address stream (slave side)
//   busy     : FSM not in IDLE
//   done     : one-cycle completion pulse
module load_sequencer
   import vTPU_pkg::*;
#(
   parameter int COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH,
   parameter int LENGTH_WIDTH  = DEFAULT_LENGTH_WIDTH,
   parameter int MATRIX_WIDTH  = DEFAULT_MATRIX_WIDTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              abort,
   load_sequencer_if.slave   bus,
   output logic              busy,
   output logic              done
);

   load_seq_state_t          state;
   logic [COUNTER_WIDTH-1:0] base;
   logic [LENGTH_WIDTH-1:0]  len;
   logic [LENGTH_WIDTH-1:0]  row;
   logic                     tile_wrap;
   logic                     row_last;
   logic                     accept;
   logic                     advance;

   // Ready is held low while reset is asserted, then follows IDLE.
   assign bus.instr_ready = rst && (state == IDLE);

   // An abort arriving with the instruction drops it.
   assign accept  = bus.instr_valid && bus.instr_ready && enable && !abort;
   assign advance = enable && (state == RUN) && !abort && !row_last;

   row_tile_counter #(
      .LENGTH_WIDTH (LENGTH_WIDTH),
      .MATRIX_WIDTH (MATRIX_WIDTH)
   ) counter (
      .clk       (clk),
      .rst       (rst),
      .clear     (accept),
      .advance   (advance),
      .len       (len),
      .row       (row),
      .tile_wrap (tile_wrap),
      .last      (row_last)
   );

   // Sequencer FSM with the latched instruction fields. Nothing moves while
   // enable is low, so a paused sequence resumes on the same row.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         base  <= '0;
         len   <= '0;
      end else if (enable) begin
         case (state)
            IDLE: begin
               if (accept) begin
                  base <= bus.instr_addr;
                  len  <= bus.instr_len;
                  if (bus.instr_len == '0) begin
                     state <= DONE;
                  end else begin
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               if (abort) begin
                  state <= IDLE;
               end else if (row_last) begin
                  state <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // The row shown is the one held in registers since the last update; the
   // enable gate hides it during a stall so each row is offered exactly once
   // in an enabled cycle.
   assign bus.addr_valid = enable && (state == RUN);
   assign bus.addr       = base + COUNTER_WIDTH'(row);
   assign bus.addr_last  = bus.addr_valid && row_last;
   assign bus.tile_last  = bus.addr_valid && (tile_wrap || row_last);

   assign busy = (state != IDLE);
   assign done = enable && (state == DONE);

endmodule

// File: tb/tb_load_sequencer.sv
// tb_load_sequencer
// Scoreboard bench for load_sequencer: the driver pushes the rows and done
// pulse each instruction should produce, stamped with the enabled cycle on
// which they must appear; the monitor pops and compares whenever the DUT
// shows addr_valid or done.
module tb_load_sequencer;

   localparam int CW = 32;
   localparam int LW = 10;
   localparam int MW = 14;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic enable = 1'b0;
   logic abort = 1'b0;
   logic busy;
   logic done;

   load_sequencer_if #(.COUNTER_WIDTH(CW), .LENGTH_WIDTH(LW)) bus ();

   load_sequencer #(
      .COUNTER_WIDTH (CW),
      .LENGTH_WIDTH  (LW),
      .MATRIX_WIDTH  (MW)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .enable (enable),
      .abort  (abort),
      .bus    (bus),
      .busy   (busy),
      .done   (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit            is_done;
      logic [CW-1:0] addr;
      bit            tile_last;
      bit            addr_last;
      int            stamp;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   ecount = 0;
   int   busy_cycles = 0;

   function automatic void check_output(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endfunction

   // Reference model: row i of an instruction accepted on enabled cycle s
   // appears on enabled cycle s+1+i; done follows the last row.
   task automatic expect_instr(input logic [CW-1:0] a, input int len, input int abort_row, input int s);
      exp_t e;
      int   n;
      n = (abort_row >= 0) ? abort_row + 1 : len;
      for (int i = 0; i < n; i++) begin
         e.is_done   = 1'b0;
         e.addr      = a + CW'(i);
         e.addr_last = (i == len - 1);
         e.tile_last = ((i % MW) == MW - 1) || (i == len - 1);
         e.stamp     = s + 1 + i;
         sb.push_back(e);
      end
      if (abort_row < 0) begin
         e.is_done   = 1'b1;
         e.addr      = '0;
         e.addr_last = 1'b0;
         e.tile_last = 1'b0;
         e.stamp     = s + 1 + len;
         sb.push_back(e);
      end
   endtask

   // Monitor: samples on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (rst) begin
         if (bus.addr_valid === 1'b1 || done === 1'b1) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_output: got addr_valid=%0b done=%0b addr=0x%0h, expected no output",
                        bus.addr_valid, done, bus.addr);
            end else begin
               mon_e = sb.pop_front();
               check_output("addr_valid", bus.addr_valid, !mon_e.is_done);
               check_output("done", done, mon_e.is_done);
               check_output("cycle", ecount, mon_e.stamp);
               check_output("tile_last", bus.tile_last, mon_e.tile_last);
               check_output("addr_last", bus.addr_last, mon_e.addr_last);
               if (!mon_e.is_done) begin
                  check_output("addr", bus.addr, mon_e.addr);
               end
            end
         end
         if (enable) ecount++;
         if (busy) busy_cycles++;
      end
   end

   // Issues one instruction and walks it to completion or abort, with
   // optional random stalls and an optional 3-cycle stall before pause_row.
   task automatic apply_stimulus(input logic [CW-1:0] a, input int len, input int abort_row,
                                 input int pause_pct, input int pause_row);
      int r;
      int guard;
      bit aborted;
      bit paused;
      r = 0;
      guard = 0;
      aborted = 1'b0;
      paused = 1'b0;
      expect_instr(a, len, abort_row, ecount);
      bus.instr_addr  = a;
      bus.instr_len   = LW'(len);
      bus.instr_valid = 1'b1;
      enable = 1'b1;
      abort  = 1'b0;
      check_output("instr_ready_at_issue", bus.instr_ready, 1);
      @(posedge clk); #1;
      bus.instr_valid = 1'b0;
      while (r < len && !aborted && guard < 4000) begin
         guard++;
         if (r == pause_row && !paused) begin
            enable = 1'b0;
            repeat (3) begin
               @(posedge clk); #1;
            end
            paused = 1'b1;
         end
         enable = ($urandom_range(99) >= pause_pct);
         abort  = enable && (r == abort_row);
         @(posedge clk); #1;
         if (enable) begin
            if (abort) aborted = 1'b1;
            else r++;
         end
         abort = 1'b0;
      end
      if (!aborted) begin
         enable = 1'b0;
         while (!enable && guard < 4000) begin
            guard++;
            enable = ($urandom_range(99) >= pause_pct);
            @(posedge clk); #1;
         end
      end
      if (guard >= 4000) begin
         checks++;
         errors++;
         $display("[TB] FAIL driver_timeout: got %0d rows, expected %0d", r, len);
      end
      enable = 1'b1;
   endtask

   initial begin
      int b0;
      int len;
      int ar;
      logic [CW-1:0] a;

      bus.instr_valid = 1'b0;
      bus.instr_addr  = '0;
      bus.instr_len   = '0;
      enable = 1'b1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_output("reset_addr_valid", bus.addr_valid, 0);
      check_output("reset_addr", bus.addr, 0);
      check_output("reset_tile_last", bus.tile_last, 0);
      check_output("reset_addr_last", bus.addr_last, 0);
      check_output("reset_busy", busy, 0);
      check_output("reset_done", done, 0);
      check_output("reset_instr_ready", bus.instr_ready, 0);

      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      check_output("ready_after_reset", bus.instr_ready, 1);

      // Basic three-row load with a busy-window measurement.
      b0 = busy_cycles;
      apply_stimulus(32'h100, 3, -1, 0, -1);
      repeat (2) begin
         @(posedge clk); #1;
      end
      check_output("busy_cycles_len3", busy_cycles - b0, 4);

      // Tile boundaries at rows 13, 27 and the final row 29.
      apply_stimulus(32'h2000, 30, -1, 0, -1);

      // No-op instruction.
      apply_stimulus(32'h55, 0, -1, 0, -1);
      check_output("ready_after_noop", bus.instr_ready, 1);

      // Stall for 3 cycles after the second row.
      apply_stimulus(32'h500, 5, -1, 0, 2);

      // Abort during row 2, then a wrapping address.
      apply_stimulus(32'h40, 8, 2, 0, -1);
      apply_stimulus(32'hFFFF_FFFF, 2, -1, 0, -1);

      // Abort together with the offered instruction drops it.
      bus.instr_addr  = 32'h77;
      bus.instr_len   = LW'(4);
      bus.instr_valid = 1'b1;
      abort  = 1'b1;
      enable = 1'b1;
      @(posedge clk); #1;
      bus.instr_valid = 1'b0;
      abort = 1'b0;
      check_output("abort_accept_busy", busy, 0);
      check_output("abort_accept_ready", bus.instr_ready, 1);
      repeat (3) begin
         @(posedge clk); #1;
      end

      // Full-scale row count.
      apply_stimulus(32'hABC00, (1 << LW) - 1, -1, 0, -1);

      // Random instructions with stalls and occasional aborts.
      for (int k = 0; k < 40; k++) begin
         a   = $urandom;
         len = int'($urandom_range(40));
         ar  = -1;
         if (len > 0 && $urandom_range(3) == 0) ar = int'($urandom_range(len - 1));
         apply_stimulus(a, len, ar, 30, -1);
      end

      repeat (3) begin
         @(posedge clk); #1;
      end
      check_output("scoreboard_drained", sb.size(), 0);

      // Reset in the middle of a sequence, away from any clock edge.
      expect_instr(32'h3000, 20, -1, ecount);
      bus.instr_addr  = 32'h3000;
      bus.instr_len   = LW'(20);
      bus.instr_valid = 1'b1;
      @(posedge clk); #1;
      bus.instr_valid = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      check_output("midrun_reset_addr_valid", bus.addr_valid, 0);
      check_output("midrun_reset_addr", bus.addr, 0);
      check_output("midrun_reset_tile_last", bus.tile_last, 0);
      check_output("midrun_reset_addr_last", bus.addr_last, 0);
      check_output("midrun_reset_busy", busy, 0);
      check_output("midrun_reset_done", done, 0);
      check_output("midrun_reset_instr_ready", bus.instr_ready, 0);
      sb.delete();
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      check_output("ready_after_midrun_reset", bus.instr_ready, 1);
      repeat (4) begin
         @(posedge clk); #1;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
